// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: one shared gate serving an entry lane and an exit
// lane, with occupancy tracking and round-robin arbitration when both lanes
// ask in the same cycle.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   entry_req   - level request, car waiting at the entry sensor
//   exit_req    - level request, car waiting at the exit sensor
//   gate_open   - registered gate actuator drive
//   grant_entry - registered, high while the gate is open for an entering car
//   grant_exit  - registered, high while the gate is open for a leaving car
//   count       - registered occupied-slot count
//   full        - count == CAPACITY
//   empty       - count == 0
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int DC_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_OPEN_IN  = 2'd1;
  localparam logic [1:0] S_OPEN_OUT = 2'd2;

  localparam logic [DC_W-1:0]  DC_LOAD = DC_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]      state;
  logic [DC_W-1:0] dcnt;
  // 1 when the last grant went to the exit lane; reset value 0 gives exit
  // the first contested grant.
  logic            last_exit;

  logic entry_ok, exit_ok, pick_entry, pick_exit;

  assign full  = (count == CAP);
  assign empty = (count == '0);

  // Ineligible requests are dropped outright, never queued.
  assign entry_ok   = entry_req & ~full;
  assign exit_ok    = exit_req & ~empty;
  assign pick_entry = entry_ok & (~exit_ok | last_exit);
  assign pick_exit  = exit_ok & ~pick_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dcnt        <= '0;
      count       <= '0;
      last_exit   <= 1'b0;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_entry) begin
            state       <= S_OPEN_IN;
            dcnt        <= DC_LOAD;
            last_exit   <= 1'b0;
            gate_open   <= 1'b1;
            grant_entry <= 1'b1;
          end else if (pick_exit) begin
            state      <= S_OPEN_OUT;
            dcnt       <= DC_LOAD;
            last_exit  <= 1'b1;
            gate_open  <= 1'b1;
            grant_exit <= 1'b1;
          end
        end
        S_OPEN_IN, S_OPEN_OUT: begin
          // The pass always completes; requests are not looked at here.
          if (dcnt == '0) begin
            state       <= S_IDLE;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            if (state == S_OPEN_IN) count <= count + ONE;
            else                    count <= count - ONE;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          dcnt        <= '0;
          gate_open   <= 1'b0;
          grant_entry <= 1'b0;
          grant_exit  <= 1'b0;
        end
      endcase
    end
  end

endmodule
